led_channel_sel: RTL
====================

LED_CHANNEL_SEL -- requirements
Module: led_channel_sel

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 8, bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- DB_CYCLES, 16, consecutive stable samples needed to accept a button level.
- SCAN_CYCLES, 1000, dwell cycles per channel in auto mode.
- SEL_W, derived as clog2(CHANNELS), not overridable.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  WIDTH*CHANNELS  channel k is din[k*WIDTH +: WIDTH].
- btn1  in  1  raw, asynchronous, bouncing advance button.
- auto  in  1  1 = auto-scan mode, 0 = manual mode.
- led  out  WIDTH  registered selected channel.
- sel  out  SEL_W  current channel index.
- adv  out  1  one-cycle pulse on every sel change.

REQ-003 The block SHALL use one clock, with an asynchronous active-low reset named rst_n.

Function
REQ-004 btn1 SHALL pass through a 2-flop synchronizer before any other logic uses it.

REQ-005 The debouncer SHALL be an FSM with states LOW, WAIT_HIGH, HIGH and WAIT_LOW:
- LOW to WAIT_HIGH when the synchronized btn is 1.
- WAIT_HIGH to HIGH after DB_CYCLES consecutive samples of 1.
- WAIT_HIGH to LOW on any sample of 0.
- HIGH and WAIT_LOW behave symmetrically.

REQ-006 The debounce counter SHALL clear on every state entry, and it SHALL saturate rather than wrap.

REQ-007 The LOW/WAIT_HIGH to HIGH transition SHALL produce a one-cycle press pulse. Release SHALL produce no pulse.

REQ-008 In manual mode (auto=0), a press pulse SHALL set sel to sel+1. sel CHANNELS-1 SHALL wrap to 0.

REQ-009 In auto mode, a scan counter SHALL count from 0 to SCAN_CYCLES-1. At terminal count it SHALL advance sel (with wrap) and return to 0.

REQ-010 In auto mode, a press pulse SHALL advance sel and clear the scan counter.

REQ-011 If a press pulse and the scan terminal count occur in the same cycle, sel SHALL advance exactly once and the scan counter SHALL clear.

REQ-012 The scan counter SHALL be held at 0 while auto=0, so that entering auto mode starts a full dwell.

REQ-013 adv SHALL be asserted for exactly the cycle in which the sel register takes its new value.

REQ-014 led SHALL be registered as the din slice selected by the registered sel. This gives one clock of latency from a din or sel change to led.

REQ-015 Channel indices of CHANNELS or above SHALL never appear on sel. The slice logic SHALL be safe for non-power-of-two CHANNELS.

REQ-016 Button press latency SHALL be 2 synchronizer cycles plus DB_CYCLES plus 1 edges from the first high sample to the sel update. led SHALL update one edge after sel.

Reset
REQ-017 While rst_n=0, the outputs SHALL hold these values:
- led = 0
- sel = 0
- adv = 0

REQ-018 While rst_n=0, internal state SHALL hold these values:
- debouncer = LOW
- debounce counter = 0
- scan counter = 0
- synchronizer flops = 0

REQ-019 Reset SHALL take effect asynchronously. Deassertion SHALL be sampled on the clock, and the first update SHALL occur on the first rising edge after rst_n=1.

REQ-020 A reset asserted mid-debounce or mid-dwell SHALL discard the partial count. A press held through reset SHALL produce no pulse until it has been released and pressed again.

Verification
REQ-021 All scenarios SHALL use WIDTH=8, CHANNELS=4, DB_CYCLES=4 and SCAN_CYCLES=8, with din = {8'h44, 8'h33, 8'h22, 8'h11}. The bench SHALL cover these directed scenarios:
- Reset: rst_n=0 asserted mid-cycle -> led=0, sel=0 immediately; after release, led=8'h11 one edge later.
- Manual press: btn1 held high for 10 cycles with auto=0 -> sel=1 at edge 7, a single adv pulse, led=8'h22 at edge 8; release produces no change.
- Bounce and wrap: btn1 toggles every 2 cycles for 12 cycles, then four clean presses -> no advance during the bounce, then sel steps 1, 2, 3, 0 with led 8'h22, 8'h33, 8'h44, 8'h11.
- Auto scan: auto=1 -> sel advances every 8 cycles, and a 30-cycle window shows sel 0 to 1 to 2 to 3.
- Collision: a press pulse aligned with the scan terminal count -> sel advances by exactly 1, and the next auto step comes 8 cycles later.
- Reset mid-operation: rst_n pulsed low for 1 cycle during WAIT_HIGH with btn1 still held -> sel=0 and no advance until btn1 is released and pressed again.

Source files
------------

// File: rtl/led_channel_sel.sv
// Channel selector for an LED bank: debounced advance button, manual or auto-scan
// selection, and a registered output slice of the selected input channel.
module led_channel_sel #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int DB_CYCLES   = 16,
  parameter int SCAN_CYCLES = 1000,
  localparam int SEL_W      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*CHANNELS-1:0] din,
  input  logic                      btn1,
  input  logic                      auto,
  output logic [WIDTH-1:0]          led,
  output logic [SEL_W-1:0]          sel,
  output logic                      adv
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int SC_W = $clog2(SCAN_CYCLES + 1);

  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} db_state_t;

  logic            sync1, sync2;
  logic            sync_ok, armed;
  db_state_t       state;
  logic [DB_W-1:0] db_cnt;
  logic [SC_W-1:0] scan_cnt;
  logic            cnt_done, cnt_sat, press, term, step;
  logic [WIDTH-1:0] slice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn1;
      sync2 <= sync1;
    end
  end

  // The synchronizer flops read 0 out of reset regardless of the pin, so a
  // button held through reset must first be seen released before presses count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ok <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sync_ok <= 1'b1;
      if (sync_ok && !sync1 && !sync2)
        armed <= 1'b1;
    end
  end

  assign cnt_done = (db_cnt == DB_W'(DB_CYCLES - 1));
  assign cnt_sat  = (db_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOW;
      db_cnt <= '0;
    end else begin
      case (state)
        LOW: begin
          if (sync2) begin
            state  <= WAIT_HIGH;
            db_cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2) begin
            state  <= LOW;
            db_cnt <= '0;
          end else if (cnt_done) begin
            state  <= HIGH;
            db_cnt <= '0;
          end else if (!cnt_sat) begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!sync2) begin
            state  <= WAIT_LOW;
            db_cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync2) begin
            state  <= HIGH;
            db_cnt <= '0;
          end else if (cnt_done) begin
            state  <= LOW;
            db_cnt <= '0;
          end else if (!cnt_sat) begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state  <= LOW;
          db_cnt <= '0;
        end
      endcase
    end
  end

  assign press = armed && (state == WAIT_HIGH) && sync2 && cnt_done;
  assign term  = auto && (scan_cnt == SC_W'(SCAN_CYCLES - 1));
  assign step  = press || term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sel      <= '0;
      adv      <= 1'b0;
    end else begin
      if (!auto || step)
        scan_cnt <= '0;
      else
        scan_cnt <= scan_cnt + 1'b1;

      adv <= step;
      if (step) begin
        if (sel == SEL_W'(CHANNELS - 1))
          sel <= '0;
        else
          sel <= sel + 1'b1;
      end
    end
  end

  // Compare-based mux so unused sel codes (non-power-of-two CHANNELS) read 0.
  always_comb begin
    slice = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k))
        slice = din[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      led <= '0;
    else
      led <= slice;
  end

endmodule
